// File: rtl/pixel_pkg.sv
// Shared layout constants and state type for the 1-bpp packed image memory.
// Used by both the frame writer and the pixel cache so address math agrees.
package pixel_pkg;

   localparam int DEF_IMG_WIDTH  = 640;
   localparam int DEF_IMG_HEIGHT = 480;
   localparam int BYTES_PER_ROW  = DEF_IMG_WIDTH / 8;
   localparam int FRAME_BYTES    = BYTES_PER_ROW * DEF_IMG_HEIGHT;

   typedef enum logic {
      S_IDLE,
      S_ACTIVE
   } bfw_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Packs a serial pixel stream into bytes, first pixel in bit 7.
// Ports: clk, reset, clear (restart), shift_en, bit_in -> byte_ready, byte_out.
module byte_assembler (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       shift_en,
   input  logic       bit_in,
   output logic       byte_ready,
   output logic [7:0] byte_out
);

   logic [6:0] sr;
   logic [2:0] idx;

   // A clear drops the partial byte; a pixel arriving with it starts a new one.
   assign byte_ready = shift_en && !clear && (idx == 3'd7);
   assign byte_out   = {sr, bit_in};

   always_ff @(posedge clk) begin
      if (reset) begin
         sr  <= '0;
         idx <= '0;
      end else if (clear) begin
         sr  <= shift_en ? {6'd0, bit_in} : 7'd0;
         idx <= shift_en ? 3'd1 : 3'd0;
      end else if (shift_en) begin
         sr  <= {sr[5:0], bit_in};
         idx <= idx + 3'd1;
      end
   end

endmodule

// File: rtl/binary_frame_writer.sv
// Write side of the 1-bpp image memory: packs raster pixels 8 per byte.
// Ports: clk, reset, frame_start, pixel_valid, pixel -> busy, wraddress,
// wdata, wren, frame_done, ones_count (only with BFW_ONES_COUNT_EN).
module binary_frame_writer #(
   parameter int IMG_WIDTH  = pixel_pkg::DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = pixel_pkg::DEF_IMG_HEIGHT,
   parameter int ADDR_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_start,
   input  logic              pixel_valid,
   input  logic              pixel,
   output logic              busy,
   output logic [ADDR_W-1:0] wraddress,
   output logic [7:0]        wdata,
   output logic              wren,
`ifdef BFW_ONES_COUNT_EN
   output logic              frame_done,
   output logic [19:0]       ones_count
`else
   output logic              frame_done
`endif
);

   import pixel_pkg::*;

   localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   bfw_state_t state, state_nxt;

   logic [XW-1:0]     x, cx;
   logic [YW-1:0]     y, cy;
   logic [ADDR_W-1:0] byte_addr, ca;
   logic              accept, row_end, last_pix;
   logic              byte_ready;
   logic [7:0]        byte_val;

   assign accept = pixel_valid && (state == S_ACTIVE || frame_start);

   // frame_start makes this cycle the origin, so its pixel sees zeroed counters.
   assign cx = frame_start ? '0 : x;
   assign cy = frame_start ? '0 : y;
   assign ca = frame_start ? '0 : byte_addr;

   assign row_end  = (cx == XW'(IMG_WIDTH - 1));
   assign last_pix = accept && row_end && (cy == YW'(IMG_HEIGHT - 1));
   assign busy     = (state == S_ACTIVE);

   byte_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (frame_start),
      .shift_en   (accept),
      .bit_in     (pixel),
      .byte_ready (byte_ready),
      .byte_out   (byte_val)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (last_pix)
         state_nxt = S_IDLE;
      else if (frame_start)
         state_nxt = S_ACTIVE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x         <= '0;
         y         <= '0;
         byte_addr <= '0;
      end else if (accept) begin
         x         <= row_end ? '0 : cx + XW'(1);
         y         <= row_end ? cy + YW'(1) : cy;
         byte_addr <= byte_ready ? ca + ADDR_W'(1) : ca;
      end else begin
         x         <= cx;
         y         <= cy;
         byte_addr <= ca;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wren       <= 1'b0;
         frame_done <= 1'b0;
         wraddress  <= '0;
         wdata      <= '0;
      end else begin
         wren       <= byte_ready;
         frame_done <= last_pix;
         if (byte_ready) begin
            wraddress <= ca;
            wdata     <= byte_val;
         end
      end
   end

`ifdef BFW_ONES_COUNT_EN
   logic [19:0] ones_cnt, ones_base;

   assign ones_base  = frame_start ? '0 : ones_cnt;
   assign ones_count = ones_cnt;

   always_ff @(posedge clk) begin
      if (reset)
         ones_cnt <= '0;
      else if (accept && pixel && ones_base != '1)
         ones_cnt <= ones_base + 20'd1;
      else
         ones_cnt <= ones_base;
   end
`endif

endmodule
